control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_pkg.sv | 51 +++++
 rtl/alu_decoder.sv | 38 +++
 rtl/control_fsm.sv | 159 +++++++++++++++
 tb/tb_control_fsm.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared state, encoding and opcode definitions for the multicycle control FSM
package control_pkg;

  typedef enum logic [4:0] {
    S_FETCH, S_LATCH, S_DECODE,
    S_MEM_ADR, S_MEM_READ, S_MEM_WAIT, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH,
    S_JUMP, S_EXEC_JALR, S_JUMP_R, S_LINK, S_EXEC_U
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_XOR  = 4'd4,
    ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_SLT = 4'd8, ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4} imm_e;
  typedef enum logic [1:0] {RES_ALU = 2'd0, RES_DMEM = 2'd1, RES_PC4 = 2'd2, RES_RET = 2'd3} result_e;
  typedef enum logic [1:0] {SRCA_PC = 2'd0, SRCA_OLD_PC = 2'd1, SRCA_RS1 = 2'd2, SRCA_ZERO = 2'd3} src_a_e;
  typedef enum logic [1:0] {SRCB_RS2 = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2} src_b_e;
  typedef enum logic [1:0] {CLS_ADD, CLS_R, CLS_I, CLS_BRANCH} alu_class_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  function automatic logic [2:0] imm_for(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: imm_for = IMM_I;
      OP_STORE:                 imm_for = IMM_S;
      OP_BRANCH:                imm_for = IMM_B;
      OP_JAL:                   imm_for = IMM_J;
      OP_LUI, OP_AUIPC:         imm_for = IMM_U;
      default:                  imm_for = 3'd0;
    endcase
  endfunction

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_R, OP_IMM, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_legal = 1'b1;
      default:                           op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps ALU class, funct3 and funct7[5] to an ALU operation
module alu_decoder
  import control_pkg::*;
(
  input  alu_class_e  alu_class,
  input  logic [2:0]  funct3,
  input  logic        funct7_b5,
  output logic [3:0]  alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_class)
      CLS_R, CLS_I: begin
        case (funct3)
          // OP-IMM has no SUBI, so funct7[5] only alters the add slot for register ops
          3'b000:  alu_control = (alu_class == CLS_R && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7_b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      CLS_BRANCH: begin
        case (funct3)
          3'b100, 3'b101: alu_control = ALU_SLT;
          3'b110, 3'b111: alu_control = ALU_SLTU;
          default:        alu_control = ALU_SUB;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multicycle RV32I control FSM driving datapath strobes and muxes
module control_fsm
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_code,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  input  logic       ALUResultLSB,
  output logic       adr_src,
  output logic       mem_write,
  output logic       IR_write,
  output logic       reg_write,
  output logic       PC_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       illegal_instr
);

  state_e     state_q, state_d;
  alu_class_e alu_class;
  logic       branch_taken;
  logic       unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_LATCH;
      S_LATCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op_code)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
          OP_R:              state_d = S_EXEC_R;
          OP_IMM:            state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JUMP;
          OP_JALR:           state_d = S_EXEC_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_EXEC_U;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEM_ADR: begin
        if (op_code == OP_LOAD)       state_d = S_MEM_READ;
        else if (op_code == OP_STORE) state_d = S_MEM_WRITE;
        else                          state_d = S_FETCH;
      end
      S_MEM_READ:                     state_d = S_MEM_WAIT;
      S_MEM_WAIT:                     state_d = S_MEM_WB;
      S_EXEC_R, S_EXEC_I, S_EXEC_U:   state_d = S_ALU_WB;
      S_EXEC_JALR:                    state_d = S_JUMP_R;
      S_JUMP, S_JUMP_R:               state_d = S_LINK;
      default:                        state_d = S_FETCH;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:         branch_taken = Zero;
      3'b001:         branch_taken = !Zero;
      3'b100, 3'b110: branch_taken = ALUResultLSB;
      3'b101, 3'b111: branch_taken = !ALUResultLSB;
      default:        branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    IR_write      = 1'b0;
    reg_write     = 1'b0;
    PC_write      = 1'b0;
    result_src    = RES_ALU;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_class     = CLS_ADD;
    illegal_instr = 1'b0;
    case (state_q)
      S_LATCH: begin
        IR_write   = 1'b1;
        PC_write   = 1'b1;
        result_src = RES_PC4;
      end
      S_DECODE: begin
        alu_src_a     = SRCA_OLD_PC;
        alu_src_b     = SRCB_IMM;
        illegal_instr = !op_legal(op_code);
      end
      S_MEM_ADR, S_EXEC_JALR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ, S_MEM_WAIT: adr_src = 1'b1;
      S_MEM_WB: begin
        result_src = RES_DMEM;
        reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_class = CLS_R;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_class = CLS_I;
      end
      S_ALU_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_class = CLS_BRANCH;
        PC_write  = branch_taken;
      end
      S_JUMP: begin
        alu_src_a = SRCA_OLD_PC;
        alu_src_b = SRCB_IMM;
        PC_write  = 1'b1;
      end
      S_JUMP_R: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        PC_write  = 1'b1;
      end
      S_LINK: begin
        result_src = RES_RET;
        reg_write  = 1'b1;
      end
      S_EXEC_U: begin
        alu_src_a = (op_code == OP_LUI) ? SRCA_ZERO : SRCA_OLD_PC;
        alu_src_b = SRCB_IMM;
      end
      default: ;
    endcase
  end

  assign imm_src = imm_for(op_code);

  alu_decoder u_alu_decoder (
    .alu_class   (alu_class),
    .funct3      (funct3),
    .funct7_b5   (funct7[5]),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_control_fsm.sv
// tb/tb_control_fsm.sv - self-checking bench for control_fsm against a per-instruction cycle model
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] op_code = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic [6:0] funct7 = 7'd0;
  logic       Zero = 1'b0;
  logic       ALUResultLSB = 1'b0;
  logic       adr_src, mem_write, IR_write, reg_write, PC_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;

  always #5 clk = ~clk;

  control_fsm dut (
    .clk(clk), .reset(reset), .op_code(op_code), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .ALUResultLSB(ALUResultLSB),
    .adr_src(adr_src), .mem_write(mem_write), .IR_write(IR_write), .reg_write(reg_write),
    .PC_write(PC_write), .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .illegal_instr(illegal_instr)
  );

  typedef logic [18:0] vec_t;
  vec_t dut_vec;
  assign dut_vec = {adr_src, mem_write, IR_write, reg_write, PC_write, result_src,
                    alu_src_a, alu_src_b, imm_src, alu_control, illegal_instr};

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RR = 7'b0110011, RI = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111;
  localparam logic [6:0] LU = 7'b0110111, AU = 7'b0010111;
  localparam logic [6:0] LEGAL [9] = '{LD, ST, RR, RI, BR, JL, JR, LU, AU};
  // funct3-indexed base op: ADD SLL SLT SLTU XOR SRL OR AND
  localparam logic [3:0] BASE_OP [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};

  int   n_pass = 0;
  int   n_total = 0;
  vec_t exp_q[$];
  logic [2:0] m_imm;

  function automatic vec_t mk(input logic adr, mw, irw, rw, pcw, input logic [1:0] rs, sa, sb,
                              input logic [3:0] alu, input logic ill);
    return {adr, mw, irw, rw, pcw, rs, sa, sb, m_imm, alu, ill};
  endfunction

  task automatic build_expected(input logic [6:0] op, input logic [2:0] f3, input logic f7b5,
                                input logic z, input logic lsb);
    logic       legal, taken;
    logic [3:0] rop, iop, bop;
    legal = 1'b0;
    foreach (LEGAL[i]) if (LEGAL[i] == op) legal = 1'b1;
    m_imm = (op == LD || op == RI || op == JR) ? 3'd0 : (op == ST) ? 3'd1 : (op == BR) ? 3'd2 :
            (op == JL) ? 3'd3 : (op == LU || op == AU) ? 3'd4 : 3'd0;
    rop = BASE_OP[f3] + ((f7b5 && (f3 == 3'd0 || f3 == 3'd5)) ? 4'd1 : 4'd0);
    iop = BASE_OP[f3] + ((f7b5 && f3 == 3'd5) ? 4'd1 : 4'd0);
    bop = f3[2] ? (f3[1] ? 4'd9 : 4'd8) : 4'd1;
    taken = (f3 == 3'd2 || f3 == 3'd3) ? 1'b0 : ((f3[2] ? lsb : z) ^ f3[0]);
    exp_q.delete();
    exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0));
    exp_q.push_back(mk(0, 0, 1, 0, 1, 2'd2, 2'd0, 2'd0, 4'd0, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 4'd0, !legal));
    case (op)
      LD: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 4'd0, 0));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0));
        exp_q.push_back(mk(0, 0, 0, 1, 0, 2'd1, 2'd0, 2'd0, 4'd0, 0));
      end
      ST: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 4'd0, 0));
        exp_q.push_back(mk(1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0));
      end
      RR, RI: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, (op == RI) ? 2'd1 : 2'd0,
                           (op == RI) ? iop : rop, 0));
        exp_q.push_back(mk(0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0));
      end
      LU, AU: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0, (op == LU) ? 2'd3 : 2'd1, 2'd1, 4'd0, 0));
        exp_q.push_back(mk(0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0));
      end
      BR: exp_q.push_back(mk(0, 0, 0, 0, taken, 2'd0, 2'd2, 2'd0, bop, 0));
      JL: begin
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2'd0, 2'd1, 2'd1, 4'd0, 0));
        exp_q.push_back(mk(0, 0, 0, 1, 0, 2'd3, 2'd0, 2'd0, 4'd0, 0));
      end
      JR: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 4'd0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2'd0, 2'd2, 2'd1, 4'd0, 0));
        exp_q.push_back(mk(0, 0, 0, 1, 0, 2'd3, 2'd0, 2'd0, 4'd0, 0));
      end
      default: ;
    endcase
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic z, input logic lsb);
    op_code = op; funct3 = f3; funct7 = f7; Zero = z; ALUResultLSB = lsb;
    build_expected(op, f3, f7[5], z, lsb);
    #1;
  endtask

  task automatic test_reset();
    drive(7'd0, 3'd0, 7'd0, 1'b0, 1'b0);
    n_total++;
    if (dut_vec !== 19'd0) $display("FAIL reset_async got %h exp %h", dut_vec, 19'd0); else n_pass++;
    repeat (3) @(negedge clk);
    #1;
    n_total++;
    if (dut_vec !== 19'd0) $display("FAIL reset_held got %h exp %h", dut_vec, 19'd0); else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_add();
    drive(RR, 3'd0, 7'd0, 1'b0, 1'b0);
    foreach (exp_q[k]) begin
      n_total++;
      if (dut_vec !== exp_q[k]) $display("FAIL add cyc%0d got %h exp %h", k, dut_vec, exp_q[k]);
      else n_pass++;
      n_total++;
      if (IR_write !== (k == 1)) $display("FAIL add_irwrite cyc%0d got %b exp %b", k, IR_write, k == 1);
      else n_pass++;
      if (k == 4) begin
        n_total++;
        if ({reg_write, result_src} !== 3'b100)
          $display("FAIL add_wb got %b exp 100", {reg_write, result_src});
        else n_pass++;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_load();
    int adr_cnt = 0;
    drive(LD, 3'd2, 7'd0, 1'b0, 1'b0);
    foreach (exp_q[k]) begin
      n_total++;
      if (dut_vec !== exp_q[k]) $display("FAIL lw cyc%0d got %h exp %h", k, dut_vec, exp_q[k]);
      else n_pass++;
      adr_cnt += int'(adr_src);
      @(negedge clk); #1;
    end
    n_total++;
    if (adr_cnt != 2) $display("FAIL lw_adr_cycles got %0d exp 2", adr_cnt); else n_pass++;
  endtask

  task automatic test_beq();
    for (int r = 0; r < 2; r++) begin
      drive(BR, 3'd0, 7'd0, (r == 0), 1'b0);
      foreach (exp_q[k]) begin
        n_total++;
        if (dut_vec !== exp_q[k]) $display("FAIL beq%0d cyc%0d got %h exp %h", r, k, dut_vec, exp_q[k]);
        else n_pass++;
        if (k == 3) begin
          n_total++;
          if (PC_write !== (r == 0)) $display("FAIL beq%0d_pcwrite got %b exp %b", r, PC_write, r == 0);
          else n_pass++;
        end
        @(negedge clk); #1;
      end
    end
    n_total++;
    if (dut_vec !== exp_q[0]) $display("FAIL beq_refetch got %h exp %h", dut_vec, exp_q[0]);
    else n_pass++;
  endtask

  task automatic test_jalr();
    int link_cyc = -1;
    drive(JR, 3'd0, 7'd0, 1'b0, 1'b0);
    for (int k = 0; k < 10 && link_cyc < 0; k++) begin
      if (k < exp_q.size()) begin
        n_total++;
        if (dut_vec !== exp_q[k]) $display("FAIL jalr cyc%0d got %h exp %h", k, dut_vec, exp_q[k]);
        else n_pass++;
      end
      if (reg_write && result_src == 2'd3) link_cyc = k;
      @(negedge clk); #1;
    end
    n_total++;
    if (link_cyc != 5) $display("FAIL jalr_link_cycle got %0d exp 5", link_cyc); else n_pass++;
  endtask

  task automatic test_illegal();
    int pulses = 0;
    drive(7'b0000000, 3'd0, 7'd0, 1'b0, 1'b0);
    foreach (exp_q[k]) begin
      n_total++;
      if (dut_vec !== exp_q[k]) $display("FAIL illegal cyc%0d got %h exp %h", k, dut_vec, exp_q[k]);
      else n_pass++;
      pulses += int'(illegal_instr);
      @(negedge clk); #1;
    end
    n_total++;
    if (pulses != 1) $display("FAIL illegal_pulses got %0d exp 1", pulses); else n_pass++;
    n_total++;
    if (dut_vec !== exp_q[0]) $display("FAIL illegal_refetch got %h exp %h", dut_vec, exp_q[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    drive(LD, 3'd2, 7'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (dut_vec !== exp_q[k]) $display("FAIL rstmid cyc%0d got %h exp %h", k, dut_vec, exp_q[k]);
      else n_pass++;
      @(negedge clk); #1;
    end
    n_total++;
    if (adr_src !== 1'b1) $display("FAIL rstmid_mem_read got %b exp 1", adr_src); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_total++;
    if (dut_vec !== exp_q[0]) $display("FAIL rstmid_async got %h exp %h", dut_vec, exp_q[0]);
    else n_pass++;
    @(negedge clk); #1;
    n_total++;
    if (dut_vec !== exp_q[0]) $display("FAIL rstmid_held got %h exp %h", dut_vec, exp_q[0]);
    else n_pass++;
    reset = 1'b1;
    #1;
    foreach (exp_q[k]) begin
      n_total++;
      if (dut_vec !== exp_q[k]) $display("FAIL rstmid_after cyc%0d got %h exp %h", k, dut_vec, exp_q[k]);
      else n_pass++;
      @(negedge clk); #1;
    end
  endtask

  task automatic test_back_to_back_random();
    logic [6:0] op;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) < 88) op = LEGAL[$urandom_range(0, 8)];
      else op = 7'($urandom);
      drive(op, 3'($urandom), 7'($urandom), 1'($urandom), 1'($urandom));
      foreach (exp_q[k]) begin
        n_total++;
        if (dut_vec !== exp_q[k])
          $display("FAIL rand%0d op%b f3%b cyc%0d got %h exp %h", n, op_code, funct3, k, dut_vec, exp_q[k]);
        else n_pass++;
        n_total++;
        if ($countones({reg_write, mem_write, IR_write}) > 1)
          $display("FAIL rand%0d_exclusive cyc%0d got %b exp at most one", n, k, {reg_write, mem_write, IR_write});
        else n_pass++;
        @(negedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_beq();
    test_jalr();
    test_illegal();
    test_reset_mid();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
